// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and
// the default operand width.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int SERIAL_SUB_WIDTH_DEF = 8;

endpackage

// File: rtl/serial_sub_fs_bit.sv
// Combinational full-subtractor cell: d = x - y - bi, bo = borrow out.
module fs_bit (
    input  logic x,
    input  logic y,
    input  logic bi,
    output logic d,
    output logic bo
);

    assign d  = x ^ y ^ bi;
    assign bo = (~x & y) | (~(x ^ y) & bi);

endmodule

// File: rtl/serial_sub.sv
// Bit-serial subtractor: diff = a - b (mod 2^WIDTH), LSB first, one bit per
// clock through a single full-subtractor cell and a borrow flip-flop.
// Start/done handshake; latency is WIDTH+1 edges from the accepted start.
// Optional macro SERIAL_SUB_OVF_EN adds the signed-overflow output ovf.
module serial_sub
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = SERIAL_SUB_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] sa_reg, sb_reg, diff_reg;
    logic             borrow_reg;
    logic [CW-1:0]    cnt_reg;
    logic             busy_reg, done_reg;
    logic             load, shift, cell_d, cell_bo;

    assign load  = (state_reg == IDLE) && start;
    assign shift = (state_reg == RUN);

    // Single subtractor cell fed by the operand LSBs and the borrow FF.
    fs_bit u_fs_bit (
        .x  (sa_reg[0]),
        .y  (sb_reg[0]),
        .bi (borrow_reg),
        .d  (cell_d),
        .bo (cell_bo)
    );

    // State register plus registered busy/done decoded from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            busy_reg  <= (state_next == RUN);
            done_reg  <= (state_next == DONE);
        end
    end

    // Next-state logic: start only honoured in IDLE, DONE lasts one cycle.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (cnt_reg == CNT_LAST) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Operand/result shift registers, borrow FF and bit counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sa_reg     <= '0;
            sb_reg     <= '0;
            diff_reg   <= '0;
            borrow_reg <= 1'b0;
            cnt_reg    <= '0;
        end else if (load) begin
            sa_reg     <= a;
            sb_reg     <= b;
            diff_reg   <= '0;
            borrow_reg <= 1'b0;
            cnt_reg    <= '0;
        end else if (shift) begin
            sa_reg     <= sa_reg >> 1;
            sb_reg     <= sb_reg >> 1;
            diff_reg   <= {cell_d, diff_reg[WIDTH-1:1]};
            borrow_reg <= cell_bo;
            cnt_reg    <= cnt_reg + 1'b1;
        end
    end

`ifdef SERIAL_SUB_OVF_EN
    logic am_reg, bm_reg, ovf_reg;

    // Operand sign capture and overflow evaluation as the MSB is produced.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            am_reg  <= 1'b0;
            bm_reg  <= 1'b0;
            ovf_reg <= 1'b0;
        end else if (load) begin
            am_reg  <= a[WIDTH-1];
            bm_reg  <= b[WIDTH-1];
            ovf_reg <= 1'b0;
        end else if (shift && (cnt_reg == CNT_LAST)) begin
            ovf_reg <= (am_reg != bm_reg) && (cell_d != am_reg);
        end
    end

    assign ovf = ovf_reg;
`endif

    assign busy   = busy_reg;
    assign done   = done_reg;
    assign diff   = diff_reg;
    assign borrow = borrow_reg;

endmodule

// File: tb/tb_serial_sub.sv
// Directed testbench for serial_sub (WIDTH=8). Also checks ovf when built
// with SERIAL_SUB_OVF_EN.
module tb_serial_sub;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] a, b;
    logic       busy, done, borrow;
    logic [7:0] diff;
`ifdef SERIAL_SUB_OVF_EN
    logic       ovf;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int done_cyc1, done_cyc2;

    serial_sub #(.WIDTH(8)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .diff   (diff),
        .borrow (borrow)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .ovf    (ovf)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one operation; optionally inject an ignored start at RUN cycle
    // inj (0-based). Returns at the done cycle (1 ns after the edge).
    task automatic run_op(input logic [7:0] va, input logic [7:0] vb,
                          input logic [7:0] ed, input logic eb, input logic eo,
                          input int inj);
        int busy_cycles;
        a = va; b = vb; start = 1'b1;
        step();
        start = 1'b0;
        a = 8'h00; b = 8'h00;
        check("load_diff_clear", {24'd0, diff}, 32'd0);
        check("load_borrow_clear", {31'd0, borrow}, 32'd0);
        busy_cycles = 0;
        while (busy && busy_cycles < 20) begin
            busy_cycles++;
            if (busy_cycles - 1 == inj) begin
                a = 8'hAA; b = 8'h55; start = 1'b1;
            end
            step();
            start = 1'b0;
        end
        check("busy_cycles", busy_cycles, 32'd8);
        check("done_pulse", {31'd0, done}, 32'd1);
        check("diff", {24'd0, diff}, {24'd0, ed});
        check("borrow", {31'd0, borrow}, {31'd0, eb});
`ifdef SERIAL_SUB_OVF_EN
        check("ovf", {31'd0, ovf}, {31'd0, eo});
`endif
        $display("op a=%02h b=%02h -> diff=%02h borrow=%0b (exp %02h/%0b ovf %0b)",
                 va, vb, diff, borrow, ed, eb, eo);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; a = 8'h00; b = 8'h00;
        step(); step();
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_diff", {24'd0, diff}, 32'd0);
        check("rst_borrow", {31'd0, borrow}, 32'd0);
        rst = 1'b0;
        step();

        // Basic, borrow/wrap and signed-overflow vectors.
        run_op(8'h35, 8'h12, 8'h23, 1'b0, 1'b0, -1);
        step();
        check("done_one_cycle", {31'd0, done}, 32'd0);
        check("diff_hold", {24'd0, diff}, 32'h23);
        run_op(8'h00, 8'h01, 8'hFF, 1'b1, 1'b0, -1); step();
        run_op(8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0, -1); step();
        run_op(8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, -1); step();
        run_op(8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1, -1); step();

        // Start during RUN cycle 3 must be ignored.
        run_op(8'h3C, 8'h5A, 8'hE2, 1'b1, 1'b0, 2); step();
        check("ignored_start_idle", {31'd0, busy}, 32'd0);

        // Asynchronous reset mid-RUN.
        a = 8'hFF; b = 8'h00; start = 1'b1;
        step();
        start = 1'b0;
        repeat (4) step();
        check("pre_rst_busy", {31'd0, busy}, 32'd1);
        check("pre_rst_diff", {24'd0, diff}, 32'hF0);
        #2 rst = 1'b1;
        #1;
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_done", {31'd0, done}, 32'd0);
        check("arst_diff", {24'd0, diff}, 32'd0);
        check("arst_borrow", {31'd0, borrow}, 32'd0);
        $display("async reset mid-RUN: busy=%0b diff=%02h", busy, diff);
        step();
        rst = 1'b0;
        step();
        run_op(8'h10, 8'h01, 8'h0F, 1'b0, 1'b0, -1); step();

        // Back-to-back: second start in the first IDLE cycle after done.
        run_op(8'hC8, 8'h64, 8'h64, 1'b0, 1'b1, -1);
        done_cyc1 = cyc;
        step();
        check("b2b_idle_done", {31'd0, done}, 32'd0);
        check("b2b_diff_hold", {24'd0, diff}, 32'h64);
        run_op(8'h64, 8'hC8, 8'h9C, 1'b1, 1'b1, -1);
        done_cyc2 = cyc;
        check("b2b_period", done_cyc2 - done_cyc1, 32'd10);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
